// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - operand/result handshake and external full-adder bit lanes
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester plus external full adder side
    modport master (
        output start, a, b, cin, fa_s, fa_cout,
        input  fa_a, fa_b, fa_cin, busy, done, sum, cout
    );

    // Serial adder controller side
    modport slave (
        input  start, a, b, cin, fa_s, fa_cout,
        output fa_a, fa_b, fa_cin, busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller driving one external full adder, LSB first
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_add_ctrl_if.slave     bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    // Holds the sum bits produced so far; the final bit comes straight from fa_s
    logic [RW-1:0]    res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    // Sequencer: capture operands, walk WIDTH bits through the adder, publish result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opa    <= bus.a;
                        opb    <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    res   <= (res >> 1) | (RW'(bus.fa_s) << (RW - 1));
                    carry <= bus.fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum_q  <= {bus.fa_s, res};
                        cout_q <= bus.fa_cout;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Adder lanes are only live in RUN so the external adder sees zeros otherwise
    assign bus.fa_a   = (state == RUN) & opa[0];
    assign bus.fa_b   = (state == RUN) & opb[0];
    assign bus.fa_cin = (state == RUN) & carry;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and random checks of serial_add_ctrl with a modelled full adder
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External full adder
    assign bus.fa_s    = bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
    assign bus.fa_cout = (bus.fa_a & bus.fa_b) | (bus.fa_a & bus.fa_cin) | (bus.fa_b & bus.fa_cin);

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] prev_sum  = '0;
    logic         prev_cout = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy"}, 64'(bus.busy), 64'd0);
        check({tag, " done"}, 64'(bus.done), 64'd0);
        check({tag, " fa_a"}, 64'(bus.fa_a), 64'd0);
        check({tag, " fa_b"}, 64'(bus.fa_b), 64'd0);
        check({tag, " fa_cin"}, 64'(bus.fa_cin), 64'd0);
        check({tag, " sum"}, 64'(bus.sum), 64'(prev_sum));
        check({tag, " cout"}, 64'(bus.cout), 64'(prev_cout));
    endtask

    task automatic scramble();
        bus.a   = W'($urandom);
        bus.b   = W'($urandom);
        bus.cin = 1'($urandom);
    endtask

    // Called at a falling edge with the controller idle; returns at the falling edge after DONE
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input bit hold);
        logic [63:0] full;
        logic [63:0] mask;
        logic [63:0] cin_k;
        full = 64'(a) + 64'(b) + 64'(ci);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = ci;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        scramble();
        for (int k = 0; k < W; k++) begin
            mask  = (64'd1 << k) - 64'd1;
            cin_k = (((64'(a) & mask) + (64'(b) & mask) + 64'(ci)) >> k) & 64'd1;
            check("run busy", 64'(bus.busy), 64'd1);
            check("run done", 64'(bus.done), 64'd0);
            check("run fa_a", 64'(bus.fa_a), 64'(a[k]));
            check("run fa_b", 64'(bus.fa_b), 64'(b[k]));
            check("run fa_cin", 64'(bus.fa_cin), cin_k);
            check("run sum hold", 64'(bus.sum), 64'(prev_sum));
            check("run cout hold", 64'(bus.cout), 64'(prev_cout));
            @(negedge clk);
            scramble();
        end
        check("done pulse", 64'(bus.done), 64'd1);
        check("done busy", 64'(bus.busy), 64'd1);
        check("done fa_a", 64'(bus.fa_a), 64'd0);
        check("done fa_cin", 64'(bus.fa_cin), 64'd0);
        check("done sum", 64'(bus.sum), full & ((64'd1 << W) - 64'd1));
        check("done cout", 64'(bus.cout), (full >> W) & 64'd1);
        prev_sum  = full[W-1:0];
        prev_cout = full[W];
        @(negedge clk);
        check_quiet("after done");
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post reset idle");

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_quiet("idle no start");
        end

        // start held high: each op is accepted at the first idle edge, done pulses 10 cycles apart
        run_op(8'h12, 8'h34, 1'b1, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 1'b1);
        run_op(8'hC3, 8'h7E, 1'b1, 1'b1);
        bus.start = 1'b0;
        @(negedge clk);
        check_quiet("held start released");

        // asynchronous reset in the fourth RUN cycle
        bus.start = 1'b1;
        bus.a     = 8'hA5;
        bus.b     = 8'h3C;
        bus.cin   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-abort busy", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        prev_sum  = '0;
        prev_cout = 1'b0;
        check_quiet("async reset");
        repeat (2) begin
            @(negedge clk);
            check_quiet("held in reset");
        end
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(negedge clk);
            check_quiet("aborted no done");
        end
        run_op(8'h01, 8'h01, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
            bus.start = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
